// File: rtl/sbox_run_ctrl_if.sv
// Host-side command/status/readback bundle for the sbox run controller.
// master = host, slave = controller.
interface sbox_run_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic [31:0]       cmd;
  logic              cmd_we;
  logic [CNT_W-1:0]  num_cycles;
  logic [1:0]        stim_sel;
  logic [WIDTH-1:0]  stim_data;
  logic              stim_we;
  logic [31:0]       status;
  logic [CNT_W-1:0]  cycles_run;
  logic              rd_req;
  logic [1:0]        rd_sel;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;

  modport master (
    output cmd, cmd_we, num_cycles,
    output stim_sel, stim_data, stim_we,
    output rd_req, rd_sel,
    input  status, cycles_run,
    input  rd_data, rd_valid
  );

  modport slave (
    input  cmd, cmd_we, num_cycles,
    input  stim_sel, stim_data, stim_we,
    input  rd_req, rd_sel,
    output status, cycles_run,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/sbox_run_ctrl.sv
// Command-side sequencer for the sbox harness: reset hold, bounded run,
// capture of the four sbox outputs and one-cycle readback.
module sbox_run_ctrl #(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  sbox_run_ctrl_if.slave   bus,
  output logic [WIDTH-1:0] inorth,
  output logic [WIDTH-1:0] iwest,
  output logic [WIDTH-1:0] isouth,
  output logic [WIDTH-1:0] ieast,
  input  logic [WIDTH-1:0] onorth,
  input  logic [WIDTH-1:0] owest,
  input  logic [WIDTH-1:0] osouth,
  input  logic [WIDTH-1:0] oeast,
  output logic             sbox_rst
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int HOLD_W = $clog2(RST_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RST_CYCLES - 1);

  logic [1:0]       state, state_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0] cyc, cyc_n;
  logic             aborted, aborted_n;
  logic             cap_en, cap_clr;
  logic             busy_q, done_q, in_rst_q;
  logic [WIDTH-1:0] cap [4];
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  logic soft_rst, run_cmd, stop_cmd;
  logic unused_cmd;

  assign soft_rst = bus.cmd_we & bus.cmd[1];
  assign run_cmd  = bus.cmd_we & (bus.cmd[1:0] == 2'b01);
  assign stop_cmd = bus.cmd_we & (bus.cmd[1:0] == 2'b00);
  assign unused_cmd = ^bus.cmd[31:2];

  always_comb begin
    state_n   = state;
    hold_n    = hold;
    rem_n     = rem;
    cyc_n     = cyc;
    aborted_n = aborted;
    cap_en    = 1'b0;
    cap_clr   = 1'b0;
    if (soft_rst) begin
      state_n   = S_RESET;
      hold_n    = '0;
      cyc_n     = '0;
      aborted_n = 1'b0;
      cap_clr   = 1'b1;
    end else begin
      case (state)
        S_RESET: begin
          if (hold == HOLD_LAST) state_n = S_READY;
          else hold_n = hold + HOLD_W'(1);
        end
        S_READY, S_DONE: begin
          if (run_cmd) begin
            rem_n     = bus.num_cycles;
            cyc_n     = '0;
            aborted_n = 1'b0;
            if (bus.num_cycles == '0) begin
              state_n = S_DONE;
              cap_en  = 1'b1;
            end else begin
              state_n = S_RUN;
            end
          end
        end
        default: begin
          // abort freezes the count at the value already reached
          if (stop_cmd) begin
            state_n   = S_DONE;
            cap_en    = 1'b1;
            aborted_n = 1'b1;
          end else begin
            cyc_n = cyc + CNT_W'(1);
            rem_n = rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state_n = S_DONE;
              cap_en  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RESET;
      hold     <= '0;
      rem      <= '0;
      cyc      <= '0;
      aborted  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      in_rst_q <= 1'b0;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      rem      <= rem_n;
      cyc      <= cyc_n;
      aborted  <= aborted_n;
      busy_q   <= (state_n == S_RUN);
      done_q   <= (state_n == S_DONE);
      in_rst_q <= (state_n == S_RESET);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inorth <= '0;
      iwest  <= '0;
      isouth <= '0;
      ieast  <= '0;
    end else if (bus.stim_we) begin
      unique case (bus.stim_sel)
        2'd0: inorth <= bus.stim_data;
        2'd1: iwest  <= bus.stim_data;
        2'd2: isouth <= bus.stim_data;
        default: ieast <= bus.stim_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cap[i] <= '0;
    end else if (cap_clr) begin
      for (int i = 0; i < 4; i++) cap[i] <= '0;
    end else if (cap_en) begin
      cap[0] <= onorth;
      cap[1] <= owest;
      cap[2] <= osouth;
      cap[3] <= oeast;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) rd_data_q <= cap[bus.rd_sel];
    end
  end

  assign sbox_rst       = (state == S_RESET);
  assign bus.status     = {28'd0, aborted, in_rst_q, done_q, busy_q};
  assign bus.cycles_run = cyc;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_sbox_run_ctrl.sv
// Directed self-checking bench for sbox_run_ctrl.
// Drives on the falling edge, samples just before the next drive.
module tb_sbox_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] inorth, iwest, isouth, ieast;
  logic [31:0] onorth, owest, osouth, oeast;
  logic sbox_rst;
  logic [31:0] tick_cnt = 0;
  logic vary = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] stim;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt [4];

  sbox_run_ctrl_if #(.WIDTH(32), .CNT_W(32)) bus ();

  sbox_run_ctrl #(.WIDTH(32), .CNT_W(32), .RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .inorth(inorth), .iwest(iwest), .isouth(isouth), .ieast(ieast),
    .onorth(onorth), .owest(owest), .osouth(osouth), .oeast(oeast),
    .sbox_rst(sbox_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick_cnt <= tick_cnt + 1;

  // sbox model: distinct affine map per direction, optionally time-varying
  assign onorth = inorth * 3 + 1 + (vary ? tick_cnt : 32'd0);
  assign owest  = iwest  * 3 + 2 + (vary ? tick_cnt : 32'd0);
  assign osouth = isouth * 3 + 3 + (vary ? tick_cnt : 32'd0);
  assign oeast  = ieast  * 3 + 4 + (vary ? tick_cnt : 32'd0);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stim_out(input logic [1:0] s);
    case (s)
      2'd0: return inorth;
      2'd1: return iwest;
      2'd2: return isouth;
      default: return ieast;
    endcase
  endfunction

  task automatic cmd_wr(input logic [31:0] c, input logic [31:0] n);
    bus.cmd = c;
    bus.num_cycles = n;
    bus.cmd_we = 1'b1;
    tick();
    bus.cmd_we = 1'b0;
  endtask

  task automatic read_cap(input logic [1:0] s, input logic [31:0] exp,
                          input string name);
    bus.rd_req = 1'b1;
    bus.rd_sel = s;
    tick();
    bus.rd_req = 1'b0;
    chk({name, "_valid"}, 64'(bus.rd_valid), 64'd1);
    chk(name, 64'(bus.rd_data), 64'(exp));
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] ab_exp [4];

    vt[0] = '{2'd0, 32'd100, 32'd301};
    vt[1] = '{2'd1, 32'd200, 32'd602};
    vt[2] = '{2'd2, 32'd300, 32'd903};
    vt[3] = '{2'd3, 32'd400, 32'd1204};

    reset = 1'b0;
    bus.cmd = '0; bus.cmd_we = 0; bus.num_cycles = '0;
    bus.stim_sel = '0; bus.stim_data = '0; bus.stim_we = 0;
    bus.rd_req = 0; bus.rd_sel = '0;
    tick();
    tick();
    chk("rst_sbox_rst", 64'(sbox_rst), 64'd1);
    chk("rst_status", 64'(bus.status), 64'd0);
    chk("rst_cycles", 64'(bus.cycles_run), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);

    // release reset and try a run that must be ignored in RESET
    reset = 1'b1;
    cmd_wr(32'd1, 32'd5);
    chk("po_hold1_sbox_rst", 64'(sbox_rst), 64'd1);
    chk("po_hold1_status", 64'(bus.status), 64'd4);
    tick();
    chk("po_ready_sbox_rst", 64'(sbox_rst), 64'd0);
    chk("po_ready_status", 64'(bus.status), 64'd0);
    tick();
    chk("po_run_ignored", 64'(bus.status), 64'd0);

    for (int i = 0; i < 4; i++) begin
      bus.stim_we = 1'b1;
      bus.stim_sel = vt[i].sel;
      bus.stim_data = vt[i].stim;
      tick();
      chk("stim_write", 64'(stim_out(vt[i].sel)), 64'(vt[i].stim));
    end
    bus.stim_we = 1'b0;

    cmd_wr(32'd1, 32'd10);
    busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (!bus.status[0]) break;
      busy_cnt++;
      tick();
    end
    chk("run10_busy_cycles", 64'(busy_cnt), 64'd10);
    chk("run10_status", 64'(bus.status), 64'd2);
    chk("run10_cycles", 64'(bus.cycles_run), 64'd10);

    // back-to-back readback of all four captures
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_sel = vt[i].sel;
      tick();
      chk("rd_valid", 64'(bus.rd_valid), 64'd1);
      chk("rd_data", 64'(bus.rd_data), 64'(vt[i].exp_rd));
    end
    bus.rd_req = 1'b0;
    tick();
    chk("rd_valid_idle", 64'(bus.rd_valid), 64'd0);

    // zero-length run captures immediately
    bus.stim_we = 1'b1; bus.stim_sel = 2'd0; bus.stim_data = 32'd7;
    tick();
    bus.stim_we = 1'b0;
    cmd_wr(32'd1, 32'd0);
    chk("zero_status", 64'(bus.status), 64'd2);
    chk("zero_cycles", 64'(bus.cycles_run), 64'd0);
    read_cap(2'd0, 32'd22, "zero_cap_n");

    // abort after 37 run cycles with time-varying sbox outputs
    vary = 1'b1;
    cmd_wr(32'd1, 32'd1000);
    for (int n = 0; n < 100; n++) begin
      if (bus.cycles_run == 32'd37) break;
      tick();
    end
    chk("abort_reach37", 64'(bus.cycles_run), 64'd37);
    ab_exp[0] = 32'd22   + tick_cnt;
    ab_exp[1] = 32'd602  + tick_cnt;
    ab_exp[2] = 32'd903  + tick_cnt;
    ab_exp[3] = 32'd1204 + tick_cnt;
    cmd_wr(32'd0, 32'd0);
    vary = 1'b0;
    chk("abort_status", 64'(bus.status), 64'd10);
    chk("abort_cycles", 64'(bus.cycles_run), 64'd37);
    for (int i = 0; i < 4; i++)
      read_cap(2'(i), ab_exp[i], "abort_cap");
    cmd_wr(32'd0, 32'd0);
    chk("noop_stop_in_done", 64'(bus.status), 64'd10);

    // soft reset + run together mid-RUN
    cmd_wr(32'd1, 32'd1000);
    tick(); tick(); tick();
    chk("sim_busy", 64'(bus.status), 64'd1);
    cmd_wr(32'd3, 32'd1000);
    chk("sim_sbox_rst1", 64'(sbox_rst), 64'd1);
    chk("sim_status", 64'(bus.status), 64'd4);
    chk("sim_cycles", 64'(bus.cycles_run), 64'd0);
    tick();
    chk("sim_sbox_rst2", 64'(sbox_rst), 64'd1);
    tick();
    chk("sim_ready", 64'(sbox_rst), 64'd0);
    chk("sim_no_run", 64'(bus.status), 64'd0);
    chk("sim_stim_n", 64'(inorth), 64'd7);
    chk("sim_stim_e", 64'(ieast), 64'd400);
    read_cap(2'd1, 32'd0, "sim_cap_cleared");

    // asynchronous reset between edges mid-RUN
    cmd_wr(32'd1, 32'd1000);
    bus.rd_req = 1'b1;
    tick();
    chk("pre_arst_rd_valid", 64'(bus.rd_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_sbox_rst", 64'(sbox_rst), 64'd1);
    chk("arst_status", 64'(bus.status), 64'd0);
    chk("arst_cycles", 64'(bus.cycles_run), 64'd0);
    chk("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("arst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("arst_stim", 64'(inorth | iwest | isouth | ieast), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbox_run_ctrl.md
# sbox_run_ctrl

Command-side controller for the sbox userlogic harness. It decodes the userlogic command register (bit 1 soft reset, bit 0 run) and sequences the switch box through reset, a bounded run of N cycles, and completion. It drives the four directional stimulus words into the sbox and captures the four directional outputs when the run ends. It exposes status, a cycle count and a one-cycle-latency readback port. It is the in-fabric counterpart of the command/status registers that the bench host writes and polls.

## Interface
- WIDTH, 32, sbox port data width
- CNT_W, 32, cycle counter / num_cycles width
- RST_CYCLES, 2, cycles sbox_rst is held high per reset entry (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd  in  32  command word: bit1 = soft reset, bit0 = run; other bits ignored
- cmd_we  in  1  cmd write strobe, sampled on clk
- num_cycles  in  CNT_W  run length, sampled on an accepted run command
- stim_sel  in  2  stimulus select: 0 N, 1 W, 2 S, 3 E
- stim_data  in  WIDTH  stimulus value
- stim_we  in  1  stimulus write strobe
- inorth/iwest/isouth/ieast  out  WIDTH  registered stimulus to the sbox
- onorth/owest/osouth/oeast  in  WIDTH  sbox outputs
- sbox_rst  out  1  active-high reset to the sbox
- status  out  32  bit0 busy (RUN), bit1 done (DONE), bit2 in_reset (RESET), bit3 aborted; others 0
- cycles_run  out  CNT_W  run cycles executed in the current/last run
- rd_req  in  1  readback request
- rd_sel  in  2  capture select: 0 N, 1 W, 2 S, 3 E
- rd_data  out  WIDTH  selected captured value
- rd_valid  out  1  one-cycle pulse qualifying rd_data

## Operation
- FSM states: RESET, READY, RUN, DONE.
- Asserting `reset` (low) has these effects:
  - state=RESET, hold counter=0, sbox_rst=1.
  - All stimulus, captures, cycles_run, rd_data, status bits and rd_valid clear to 0.
- RESET:
  - sbox_rst=1 for RST_CYCLES cycles.
  - Then go to READY with sbox_rst=0.
  - Run commands are ignored in this state.
- Soft reset: cmd_we with cmd[1]=1 in any state.
  - Enter RESET, reload the hold counter, clear cycles_run, the captures and aborted.
  - Stimulus registers are kept.
  - If cmd[0] is also set, reset wins and the run is discarded.
- Run: cmd_we with cmd[1:0]=01 in READY or DONE.
  - Latch remaining=num_cycles, clear cycles_run and aborted.
  - If num_cycles≠0, go to RUN.
  - If num_cycles=0, go directly to DONE with an immediate capture and cycles_run=0.
  - A run command while in RUN is ignored.
- RUN, each cycle: cycles_run+1, remaining−1.
  - On the cycle where remaining goes 1→0, go to DONE.
  - On the same edge, capture onorth/owest/osouth/oeast.
- Abort: cmd_we with cmd[1:0]=00 in RUN.
  - Go to DONE, capture, set aborted=1.
  - cycles_run holds the count reached; no increment on the abort edge.
  - cmd=00 in any other state is a no-op.
- DONE holds captures and cycles_run until the next run or reset.
- Stimulus writes are accepted in every state: stim_we writes stim_data to the selected port register.
- Readback:
  - rd_req registers rd_data=capture[rd_sel] and rd_valid=1 on the next edge.
  - rd_valid is 0 otherwise; back-to-back requests give back-to-back valid pulses.
  - Reads during RUN return the previous captures (0 after reset).
- No arithmetic wrap: cycles_run ≤ num_cycles ≤ 2^CNT_W−1.

## Timing
- sbox_rst, stimulus, status, cycles_run and the capture registers are all registered, with no combinational input→output paths.
- Stimulus write at edge k is visible on i* after edge k.
- Run accepted at edge k gives status.busy=1 after k. DONE is reached after edge k+N, with cycles_run=N and the captures taken at that edge.
- Soft reset at edge k gives sbox_rst=1 after k; READY (sbox_rst=0) follows after edge k+RST_CYCLES.
- Readback latency is 1 cycle.
- Async reset applied mid-RUN takes effect immediately and discards the run.

## Test plan
- Power-on:
  - Expected: after reset release, sbox_rst=1 for 2 cycles, then READY, status=0.
  - Run issued during RESET is ignored: no busy.
- Stimulus and short run:
  - Stimulus: write stim 100/200/300/400 (N/W/S/E), run with num_cycles=10, sbox outputs modelled as a fixed function.
  - Expected: busy for exactly 10 cycles, then done=1, cycles_run=10, readback sel0..3 returns the modelled values one cycle after each rd_req.
- Zero length: num_cycles=0.
  - Expected: next cycle done=1, busy never set, cycles_run=0.
- Abort: run 1000 cycles, write cmd=0 at cycle 37.
  - Expected: done=1, aborted=1, cycles_run=37, captures equal sbox outputs at that edge.
- Simultaneous command: cmd=3 mid-RUN.
  - Expected: RESET entered, sbox_rst=1 for 2 cycles, cycles_run=0, run not started, stimulus registers unchanged.
- Mid-run reset:
  - Stimulus: assert reset (low) asynchronously mid-RUN, between clock edges.
  - Expected: all outputs 0, sbox_rst=1, rd_valid=0 immediately.
